// File: rtl/arbitro_memoria_pkg.sv
// Shared definitions for the CPUCR main-memory arbiter: sequencer states,
// requester identifiers and the opcode mnemonics used when preloading memory.
package arbitro_memoria_pkg;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESO = 2'd1,
    FIN    = 2'd2
  } estado_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // CPUCR opcode mnemonics
  localparam logic [7:0] OP_ORAINM = 8'h43;
  localparam logic [7:0] OP_HLT    = 8'h7F;

endpackage

// File: rtl/arbitro_memoria_rr.sv
// Two-way round-robin picker: on a tie the requester that did not own the
// last grant wins; a lone requester always wins.
module arbitro_rr
  import arbitro_memoria_pkg::*;
(
  input  logic i_req_cpu,
  input  logic i_req_dma,
  input  logic i_dueno,
  output logic o_valido_c,
  output logic o_ganador_c
);

  always_comb begin
    o_valido_c  = i_req_cpu | i_req_dma;
    o_ganador_c = REQ_CPU;
    if (i_req_cpu && i_req_dma) begin
      o_ganador_c = ~i_dueno;
    end else if (i_req_dma) begin
      o_ganador_c = REQ_DMA;
    end
  end

endmodule

// File: rtl/arbitro_memoria.sv
// CPU/DMA arbiter and sequencer for the 64K x 8 main memory: owns the address
// bus, the LE strobe and the shared data bus, one access per three cycles.
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Cpu_Req,
  input  logic          Cpu_WE,
  input  logic [AW-1:0] Cpu_Dir,
  input  logic [DW-1:0] Cpu_WDatos,
  output logic          Cpu_Ack,
  output logic [DW-1:0] Cpu_RDatos,
  input  logic          Dma_Req,
  input  logic          Dma_WE,
  input  logic [AW-1:0] Dma_Dir,
  input  logic [DW-1:0] Dma_WDatos,
  output logic          Dma_Ack,
  output logic [DW-1:0] Dma_RDatos,
  output logic [AW-1:0] Mem_Direccion,
  output logic          Mem_LE,
  inout  wire  [DW-1:0] Mem_Datos,
  output logic          Ocupado,
  output logic          Dueno
);

  estado_t       r_estado;
  logic          r_we;
  logic [DW-1:0] r_wdatos;
  logic [AW-1:0] r_mem_dir;
  logic          r_mem_le;
  logic          r_drive;
  logic          r_dueno;
  logic          r_ocupado;
  logic          r_cpu_ack;
  logic          r_dma_ack;
  logic [DW-1:0] r_cpu_rdatos;
  logic [DW-1:0] r_dma_rdatos;

  logic          w_valido;
  logic          w_ganador;
  logic          w_we_sel;
  logic [AW-1:0] w_dir_sel;
  logic [DW-1:0] w_wdatos_sel;

  arbitro_rr u_rr (
    .i_req_cpu   (Cpu_Req),
    .i_req_dma   (Dma_Req),
    .i_dueno     (r_dueno),
    .o_valido_c  (w_valido),
    .o_ganador_c (w_ganador)
  );

  assign w_we_sel     = (w_ganador == REQ_DMA) ? Dma_WE     : Cpu_WE;
  assign w_dir_sel    = (w_ganador == REQ_DMA) ? Dma_Dir    : Cpu_Dir;
  assign w_wdatos_sel = (w_ganador == REQ_DMA) ? Dma_WDatos : Cpu_WDatos;

  // Drive enable and LE are registered together, so the bus is only ever
  // driven while LE is low and the memory's read driver is off.
  assign Mem_Datos = r_drive ? r_wdatos : {DW{1'bz}};

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_estado     <= IDLE;
      r_we         <= 1'b0;
      r_wdatos     <= '0;
      r_mem_dir    <= '0;
      r_mem_le     <= 1'b1;
      r_drive      <= 1'b0;
      r_dueno      <= REQ_DMA;
      r_ocupado    <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_cpu_rdatos <= '0;
      r_dma_rdatos <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (w_valido) begin
            r_dueno   <= w_ganador;
            r_we      <= w_we_sel;
            r_wdatos  <= w_wdatos_sel;
            r_mem_dir <= w_dir_sel;
            r_mem_le  <= ~w_we_sel;
            r_drive   <= w_we_sel;
            r_ocupado <= 1'b1;
            r_estado  <= ACCESO;
          end
        end
        ACCESO: begin
          // Reads capture the asynchronous memory output at the end of ACCESO
          if (!r_we) begin
            if (r_dueno == REQ_DMA) begin
              r_dma_rdatos <= Mem_Datos;
            end else begin
              r_cpu_rdatos <= Mem_Datos;
            end
          end
          r_mem_le  <= 1'b1;
          r_drive   <= 1'b0;
          r_cpu_ack <= (r_dueno == REQ_CPU);
          r_dma_ack <= (r_dueno == REQ_DMA);
          r_estado  <= FIN;
        end
        FIN: begin
          r_ocupado <= 1'b0;
          r_estado  <= IDLE;
        end
        default: begin
          r_mem_le  <= 1'b1;
          r_drive   <= 1'b0;
          r_ocupado <= 1'b0;
          r_estado  <= IDLE;
        end
      endcase
    end
  end

  assign Cpu_Ack       = r_cpu_ack;
  assign Dma_Ack       = r_dma_ack;
  assign Cpu_RDatos    = r_cpu_rdatos;
  assign Dma_RDatos    = r_dma_rdatos;
  assign Mem_Direccion = r_mem_dir;
  assign Mem_LE        = r_mem_le;
  assign Ocupado       = r_ocupado;
  assign Dueno         = r_dueno;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Scoreboard bench for arbitro_memoria: a behavioural 64K x 8 memory on the
// bus, a reference memory array predicting read data, and an ack monitor.
module tb_arbitro_memoria;
  import arbitro_memoria_pkg::*;

  logic        CLK;
  logic        Reset;
  logic        Cpu_Req, Cpu_WE, Dma_Req, Dma_WE;
  logic [15:0] Cpu_Dir, Dma_Dir;
  logic [7:0]  Cpu_WDatos, Dma_WDatos;
  logic        Cpu_Ack, Dma_Ack;
  logic [7:0]  Cpu_RDatos, Dma_RDatos;
  logic [15:0] Mem_Direccion;
  logic        Mem_LE;
  wire  [7:0]  mem_datos;
  logic        Ocupado, Dueno;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    logic       we;
    logic [7:0] d;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dma_q[$];
  bit   ord_q[$];
  bit   m_last;
  int   total = 0;
  int   bad   = 0;
  int   lo_cnt = 0;

  arbitro_memoria dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .Cpu_Req       (Cpu_Req),
    .Cpu_WE        (Cpu_WE),
    .Cpu_Dir       (Cpu_Dir),
    .Cpu_WDatos    (Cpu_WDatos),
    .Cpu_Ack       (Cpu_Ack),
    .Cpu_RDatos    (Cpu_RDatos),
    .Dma_Req       (Dma_Req),
    .Dma_WE        (Dma_WE),
    .Dma_Dir       (Dma_Dir),
    .Dma_WDatos    (Dma_WDatos),
    .Dma_Ack       (Dma_Ack),
    .Dma_RDatos    (Dma_RDatos),
    .Mem_Direccion (Mem_Direccion),
    .Mem_LE        (Mem_LE),
    .Mem_Datos     (mem_datos),
    .Ocupado       (Ocupado),
    .Dueno         (Dueno)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory device: asynchronous read while LE=1, write taken on the LE fall
  assign mem_datos = Mem_LE ? mem[Mem_Direccion] : 8'hzz;
  always @(negedge Mem_LE) begin
    #1;
    mem[Mem_Direccion] = mem_datos;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic check_ack(input bit p);
    exp_t e;
    bit   o;
    if ((p ? dma_q.size() : cpu_q.size()) == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_ack port=%0d actual=1 required=0 @%0t", p, $time);
    end else begin
      e = p ? dma_q.pop_front() : cpu_q.pop_front();
      if (!e.we) chk(p ? "dma_rdatos" : "cpu_rdatos", p ? Dma_RDatos : Cpu_RDatos, e.d);
      chk("dueno_at_ack", Dueno, p);
      if (ord_q.size() != 0) begin
        o = ord_q.pop_front();
        chk("grant_order", p, o);
      end
    end
  endtask

  // Ack monitor and LE pulse-width checker
  always @(negedge CLK) begin
    if (!Reset) begin
      if (Cpu_Ack) check_ack(1'b0);
      if (Dma_Ack) check_ack(1'b1);
      if (!Mem_LE) begin
        lo_cnt++;
      end else if (lo_cnt != 0) begin
        chk("le_low_width", lo_cnt, 1);
        lo_cnt = 0;
      end
    end
  end

  // One access on port p; lat>0 checks negedges from request to ack,
  // scr alters address/data the cycle after the grant.
  task automatic acc(input bit p, input bit we, input logic [15:0] a, input logic [7:0] d,
                     input int lat, input bit keep, input bit scr);
    exp_t e;
    int   n;
    bit   got;
    e.we = we;
    e.d  = we ? d : ref_mem[a];
    if (we) ref_mem[a] = d;
    if (p) dma_q.push_back(e); else cpu_q.push_back(e);
    if (p) begin
      Dma_WE = we; Dma_Dir = a; Dma_WDatos = d; Dma_Req = 1'b1;
    end else begin
      Cpu_WE = we; Cpu_Dir = a; Cpu_WDatos = d; Cpu_Req = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge CLK);
      n++;
      if (scr && n == 1) begin
        if (p) begin Dma_Dir = ~a; Dma_WDatos = ~d; end
        else   begin Cpu_Dir = ~a; Cpu_WDatos = ~d; end
      end
      got = p ? Dma_Ack : Cpu_Ack;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout port=%0d actual=none required=ack @%0t", p, $time);
    end else begin
      m_last = p;
      if (lat > 0) chk("latency", n, lat);
    end
    if (!keep) begin
      if (p) Dma_Req = 1'b0; else Cpu_Req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[0] = OP_ORAINM; ref_mem[0] = OP_ORAINM;
    mem[2] = OP_HLT;    ref_mem[2] = OP_HLT;

    Reset = 1'b1;
    Cpu_Req = 0; Cpu_WE = 0; Cpu_Dir = 0; Cpu_WDatos = 0;
    Dma_Req = 0; Dma_WE = 0; Dma_Dir = 0; Dma_WDatos = 0;
    m_last = 1'b1;

    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_le", Mem_LE, 1);
    chk("rst_cpu_ack", Cpu_Ack, 0);
    chk("rst_dma_ack", Dma_Ack, 0);
    chk("rst_ocupado", Ocupado, 0);
    chk("rst_dueno", Dueno, 1);
    chk("rst_dir", Mem_Direccion, 0);
    chk("rst_cpu_rd", Cpu_RDatos, 0);
    chk("rst_dma_rd", Dma_RDatos, 0);
    Reset = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_ocupado", Ocupado, 0);
    chk("idle_le", Mem_LE, 1);

    // CPU write then read-back
    acc(0, 1, 16'h0010, 8'hA5, 2, 0, 0);
    @(negedge CLK);
    acc(0, 0, 16'h0010, 8'h00, 2, 0, 0);
    @(negedge CLK);

    // Continuous contention: grants alternate, starting with the non-owner
    begin
      bit f;
      f = ~m_last;
      for (int i = 0; i < 6; i++) ord_q.push_back(f ^ i[0]);
    end
    fork
      for (int i = 0; i < 3; i++) acc(0, 0, 16'h0000, 8'h00, -1, i < 2, 0);
      for (int j = 0; j < 3; j++) acc(1, 0, 16'h0002, 8'h00, -1, j < 2, 0);
    join
    @(negedge CLK);

    // DMA write at the top address, CPU reads it back
    acc(1, 1, 16'hFFFF, 8'h3C, 2, 0, 0);
    @(negedge CLK);
    acc(0, 0, 16'hFFFF, 8'h00, 2, 0, 0);
    @(negedge CLK);
    chk("dueno_after_cpu", Dueno, 0);

    // Inputs changed after the grant must not affect the access
    acc(0, 1, 16'h1234, 8'h5A, 2, 0, 1);
    @(negedge CLK);
    acc(0, 0, 16'h1234, 8'h00, 2, 0, 0);
    @(negedge CLK);
    acc(0, 0, 16'hEDCB, 8'h00, 2, 0, 0);
    @(negedge CLK);

    // Reset in the middle of a DMA read
    Dma_WE = 0; Dma_Dir = 16'h0002; Dma_Req = 1'b1;
    @(negedge CLK);
    chk("mid_ocupado", Ocupado, 1);
    Cpu_WE = 0; Cpu_Dir = 16'h0000; Cpu_Req = 1'b1;
    Reset = 1'b1;
    #1;
    chk("mid_rst_le", Mem_LE, 1);
    chk("mid_rst_ocupado", Ocupado, 0);
    chk("mid_rst_dueno", Dueno, 1);
    @(negedge CLK);
    chk("mid_rst_dma_ack", Dma_Ack, 0);
    chk("mid_rst_dma_rd", Dma_RDatos, 0);
    Reset = 1'b0;
    m_last = 1'b1;
    ord_q.push_back(1'b0);
    ord_q.push_back(1'b1);
    fork
      acc(0, 0, 16'h0000, 8'h00, 2, 0, 0);
      acc(1, 0, 16'h0002, 8'h00, -1, 0, 0);
    join
    @(negedge CLK);

    // Random traffic on disjoint address halves
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(3, 0)) @(negedge CLK);
        acc(0, 1'($urandom_range(1, 0)), 16'($urandom_range(16'h7FFF, 16'h0100)),
            8'($urandom), -1, 0, 0);
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(3, 0)) @(negedge CLK);
        acc(1, 1'($urandom_range(1, 0)), 16'($urandom_range(16'hFFFE, 16'h8000)),
            8'($urandom), -1, 0, 0);
      end
    join

    repeat (5) @(negedge CLK);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dma_q_drained", dma_q.size(), 0);
    chk("end_ocupado", Ocupado, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
